// File: rtl/ex_issue_pkg.sv
// rtl/ex_issue_pkg.sv - shared RV32I ALU select, opcode and width definitions for ex_issue
package ex_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_sel_e f3_to_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ex_issue_dec.sv
// rtl/ex_issue_dec.sv - combinational RV32I decode to ALU operands/select and tags
// Optional illegal-encoding flag enabled by EX_ISSUE_ILLEGAL_EN.
module ex_issue_dec
  import ex_issue_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [31:0]      i_instr,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_sel,
  output logic [4:0]       o_rd,
  output logic             o_wb_en,
  output logic             o_is_branch,
  output logic [2:0]       o_br_funct3,
  output logic [WIDTH-1:0] o_store_data,
  output logic             o_illegal
);

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [WIDTH-1:0] w_imm_i;
  logic [WIDTH-1:0] w_imm_s;
  logic [WIDTH-1:0] w_imm_u;
  logic             w_known;
  logic             w_bad;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_f7    = i_instr[31:25];
  assign w_imm_i = WIDTH'($signed(i_instr[31:20]));
  assign w_imm_s = WIDTH'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_u = WIDTH'($signed({i_instr[31:12], 12'b0}));

  always_comb begin
    o_alu_a      = '0;
    o_alu_b      = '0;
    o_alu_sel    = ALU_ADD;
    o_rd         = '0;
    o_wb_en      = 1'b0;
    o_is_branch  = 1'b0;
    o_br_funct3  = '0;
    o_store_data = '0;
    o_illegal    = 1'b0;
    w_known      = 1'b1;
    w_bad        = 1'b0;
    case (w_opc)
      OPC_OP: begin
        o_alu_a   = i_rs1_data;
        o_alu_b   = i_rs2_data;
        o_alu_sel = f3_to_sel(w_f3, w_f7[5]);
        o_rd      = i_instr[11:7];
        o_wb_en   = 1'b1;
        w_bad     = !(w_f7 == 7'h00 || w_f7 == 7'h20) ||
                    (w_f7 == 7'h20 && w_f3 != 3'd0 && w_f3 != 3'd5);
      end
      OPC_OPIMM: begin
        o_alu_a   = i_rs1_data;
        o_alu_b   = w_imm_i;
        o_alu_sel = f3_to_sel(w_f3, w_f3 == 3'd5 && w_f7[5]);
        o_rd      = i_instr[11:7];
        o_wb_en   = 1'b1;
        w_bad     = (w_f3 == 3'd1 && w_f7 != 7'h00) ||
                    (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20);
      end
      OPC_LUI, OPC_AUIPC: begin
        o_alu_a = (w_opc == OPC_AUIPC) ? i_pc : '0;
        o_alu_b = w_imm_u;
        o_rd    = i_instr[11:7];
        o_wb_en = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        o_alu_a = i_pc;
        o_alu_b = WIDTH'(4);
        o_rd    = i_instr[11:7];
        o_wb_en = 1'b1;
      end
      OPC_BRANCH: begin
        o_alu_a     = i_rs1_data;
        o_alu_b     = i_rs2_data;
        o_alu_sel   = ALU_SUB;
        o_is_branch = 1'b1;
        o_br_funct3 = w_f3;
        w_bad       = (w_f3 == 3'd2 || w_f3 == 3'd3);
      end
      OPC_LOAD: begin
        o_alu_a = i_rs1_data;
        o_alu_b = w_imm_i;
        o_rd    = i_instr[11:7];
        o_wb_en = 1'b1;
      end
      OPC_STORE: begin
        o_alu_a      = i_rs1_data;
        o_alu_b      = w_imm_s;
        o_store_data = i_rs2_data;
      end
      default: w_known = 1'b0;
    endcase
    if (o_rd == 5'd0) o_wb_en = 1'b0;
`ifdef EX_ISSUE_ILLEGAL_EN
    if (w_bad || !w_known) begin
      o_illegal = 1'b1;
      o_wb_en   = 1'b0;
    end
`else
    // Without the flag, bad encodings collapse to the same NOP as unknown opcodes
    if (w_bad) begin
      o_alu_a      = '0;
      o_alu_b      = '0;
      o_alu_sel    = ALU_ADD;
      o_rd         = '0;
      o_wb_en      = 1'b0;
      o_is_branch  = 1'b0;
      o_br_funct3  = '0;
      o_store_data = '0;
    end
`endif
  end

endmodule

// File: rtl/ex_issue.sv
// rtl/ex_issue.sv - ID/EX issue stage: decode plus 2-entry skid buffer with flush
// Optional illegal-encoding flag enabled by EX_ISSUE_ILLEGAL_EN.
module ex_issue
  import ex_issue_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic [4:0]       rd,
  output logic             wb_en,
  output logic             is_branch,
  output logic [2:0]       br_funct3,
  output logic [WIDTH-1:0] store_data,
  output logic             illegal
);

  localparam int PW = 3 * WIDTH + 15;

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic [3:0]       w_alu_sel;
  logic [4:0]       w_rd;
  logic             w_wb_en;
  logic             w_is_branch;
  logic [2:0]       w_br_funct3;
  logic [WIDTH-1:0] w_store_data;
  logic             w_illegal;
  logic [PW-1:0]    w_dec_pl;
  logic             w_accept;
  logic             w_issue;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_skid;
  logic             r_head_v;
  logic             r_skid_v;

  ex_issue_dec #(.WIDTH(WIDTH)) u_dec (
    .i_instr      (instr),
    .i_pc         (pc),
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .o_alu_a      (w_alu_a),
    .o_alu_b      (w_alu_b),
    .o_alu_sel    (w_alu_sel),
    .o_rd         (w_rd),
    .o_wb_en      (w_wb_en),
    .o_is_branch  (w_is_branch),
    .o_br_funct3  (w_br_funct3),
    .o_store_data (w_store_data),
    .o_illegal    (w_illegal)
  );

  assign w_dec_pl = {w_alu_a, w_alu_b, w_alu_sel, w_rd, w_wb_en, w_is_branch,
                     w_br_funct3, w_store_data, w_illegal};
  assign w_accept = in_valid && !r_skid_v;
  assign w_issue  = r_head_v && out_ready;

  // Skid only fills while the head is stalled, so an empty head implies an empty skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_head_v || w_issue) begin
      if (r_skid_v) begin
        r_head   <= r_skid;
        r_head_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_head_v <= w_accept;
        if (w_accept) r_head <= w_dec_pl;
      end
    end else if (w_accept) begin
      r_skid   <= w_dec_pl;
      r_skid_v <= 1'b1;
    end
  end

  assign in_ready  = !r_skid_v;
  assign out_valid = r_head_v;
  assign {alu_a, alu_b, alu_sel, rd, wb_en, is_branch, br_funct3, store_data, illegal} = r_head;

endmodule

// File: tb/tb_ex_issue.sv
// tb/tb_ex_issue.sv - self-checking bench for ex_issue with a queue-based reference model
module tb_ex_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, wb_en, is_branch, illegal;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_sel;
  logic [4:0]  rd;
  logic [2:0]  br_funct3;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a, b, sd;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wb, br, ill;
    logic [2:0]  f3;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  ex_issue #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .rd(rd), .wb_en(wb_en), .is_branch(is_branch),
    .br_funct3(br_funct3), .store_data(store_data), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode: ALU op names per RV32I mnemonic, values ADD=0..SLTU=9
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] p,
                                     input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e = '0;
    logic [3:0]  tbl [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] ui = {ins[31:12], 12'h000};
    int          f3 = int'(ins[14:12]);
    int          f7 = int'(ins[31:25]);
    bit          bad = 0;
    bit          known = 1;
    case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; e.sel = tbl[f3]; e.rd = ins[11:7]; e.wb = 1;
        if (f7 == 32 && f3 == 0) e.sel = 4'd1;
        if (f7 == 32 && f3 == 5) e.sel = 4'd7;
        bad = !(f7 == 0 || f7 == 32) || (f7 == 32 && f3 != 0 && f3 != 5);
      end
      7'h13: begin
        e.a = r1; e.b = ii; e.sel = tbl[f3]; e.rd = ins[11:7]; e.wb = 1;
        if (f3 == 5 && ins[30]) e.sel = 4'd7;
        bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end
      7'h37: begin e.b = ui; e.rd = ins[11:7]; e.wb = 1; end
      7'h17: begin e.a = p; e.b = ui; e.rd = ins[11:7]; e.wb = 1; end
      7'h6F, 7'h67: begin e.a = p; e.b = 4; e.rd = ins[11:7]; e.wb = 1; end
      7'h63: begin
        e.a = r1; e.b = r2; e.sel = 4'd1; e.br = 1; e.f3 = ins[14:12];
        bad = (f3 == 2 || f3 == 3);
      end
      7'h03: begin e.a = r1; e.b = ii; e.rd = ins[11:7]; e.wb = 1; end
      7'h23: begin e.a = r1; e.b = si; e.sd = r2; end
      default: known = 0;
    endcase
    if (e.rd == 0) e.wb = 0;
`ifdef EX_ISSUE_ILLEGAL_EN
    if (bad || !known) begin e.ill = 1; e.wb = 0; end
`else
    if (bad) e = '0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0B};
    logic [31:0] r = $urandom;
    r[6:0] = opcs[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".alu_a"}, alu_a, q[0].a);
      chk({tag, ".alu_b"}, alu_b, q[0].b);
      chk({tag, ".alu_sel"}, 32'(alu_sel), 32'(q[0].sel));
      chk({tag, ".rd"}, 32'(rd), 32'(q[0].rd));
      chk({tag, ".wb_en"}, 32'(wb_en), 32'(q[0].wb));
      chk({tag, ".is_branch"}, 32'(is_branch), 32'(q[0].br));
      chk({tag, ".br_funct3"}, 32'(br_funct3), 32'(q[0].f3));
      chk({tag, ".store_data"}, store_data, q[0].sd);
      chk({tag, ".illegal"}, 32'(illegal), 32'(q[0].ill));
    end
  endtask

  // Drive one cycle at the falling edge, advance the model, check at the next falling edge
  task automatic cyc(input string tag, input logic v, input logic [31:0] ins,
                     input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2,
                     input logic ordy, input logic fl);
    bit acc, iss;
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    out_ready = ordy; flush = fl;
    acc = v && (q.size() < 2);
    iss = ordy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (iss) q.delete(0);
      if (acc) q.push_back(model_dec(ins, p, r1, r2));
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_b", alu_b, 32'd0);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    rst = 1'b0;

    cyc("add", 1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);
    chk("add.sel", 32'(alu_sel), 32'd0);
    chk("add.a", alu_a, 32'd5);
    chk("add.b", alu_b, 32'd7);
    chk("add.rd", 32'(rd), 32'd3);
    chk("add.wb", 32'(wb_en), 32'd1);
    cyc("srai", 1, 32'h40335293, 32'h0, 32'h80000000, 32'd9, 1, 0);
    chk("srai.sel", 32'(alu_sel), 32'd7);
    chk("srai.shamt", 32'(alu_b[4:0]), 32'd3);
    chk("srai.rd", 32'(rd), 32'd5);
    cyc("sub", 1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1, 0);
    chk("sub.sel", 32'(alu_sel), 32'd1);
    cyc("lui", 1, 32'h123450B7, 32'h100, 32'd1, 32'd2, 1, 0);
    chk("lui.a", alu_a, 32'd0);
    chk("lui.b", alu_b, 32'h12345000);
    chk("lui.wb", 32'(wb_en), 32'd1);
    cyc("drain", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    cyc("bp1", 1, 32'h00100093, 32'h0, 32'd1, 32'd0, 0, 0);
    cyc("bp2", 1, 32'h00200113, 32'h0, 32'd2, 32'd0, 0, 0);
    chk("bp2.in_ready_low", 32'(in_ready), 32'd0);
    cyc("bp3", 1, 32'h00300193, 32'h0, 32'd3, 32'd0, 0, 0);
    cyc("bp4", 1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1, 0);
    cyc("bp5", 1, 32'h00300193, 32'h0, 32'd3, 32'd0, 1, 0);
    cyc("bp6", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    cyc("bp7", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

    cyc("fl1", 1, 32'h00a00513, 32'h0, 32'd4, 32'd0, 0, 0);
    cyc("fl2", 1, 32'h00b00593, 32'h0, 32'd5, 32'd0, 0, 0);
    cyc("fl3", 1, 32'h00c00613, 32'h0, 32'd6, 32'd0, 0, 1);
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    cyc("fl4", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    cyc("fl5", 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);

`ifdef EX_ISSUE_ILLEGAL_EN
    cyc("ill", 1, 32'h0000000B, 32'h0, 32'd1, 32'd2, 1, 0);
    chk("ill.flag", 32'(illegal), 32'd1);
    chk("ill.wb", 32'(wb_en), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
          ($urandom_range(0, 4) < 3), ($urandom_range(0, 31) == 0));
    end

    cyc("mr1", 1, 32'h00100093, 32'h0, 32'd1, 32'd0, 0, 0);
    cyc("mr2", 1, 32'h00200113, 32'h0, 32'd2, 32'd0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    chk("midrst.alu_a", alu_a, 32'd0);
    chk("midrst.rd", 32'(rd), 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst", 1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
